// File: rtl/sacc_pkg.sv
// Shared types and constants for the signed frame accumulator.
package sacc_pkg;

    localparam int DATA_W = 4;

    localparam logic signed [DATA_W-1:0] SAT_POS = 4'sd7;
    localparam logic signed [DATA_W-1:0] SAT_NEG = -4'sd8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } sacc_state_e;

endpackage

// File: rtl/four_bit_signed_adder_with_ov.sv
// 4-bit two's-complement ripple-carry adder with carry-out and signed overflow.
module four_bit_signed_adder_with_ov
    import sacc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout,
    output logic              ov
);

    logic [DATA_W:0] carry;

    always_comb begin
        carry[0] = cin;
        for (int i = 0; i < DATA_W; i++) begin
            sum[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = carry[DATA_W];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ov   = carry[DATA_W] ^ carry[DATA_W-1];

endmodule

// File: rtl/signed_frame_accumulator.sv
// Accumulates framed 4-bit signed operands and hands off sum/overflow/count.
// Define SACC_SATURATE_EN to clamp the accumulator on overflow instead of wrapping.
module signed_frame_accumulator
    import sacc_pkg::*;
#(
    parameter  int MAX_BEATS = 4,
    localparam int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_ov,
    output logic [CNT_W-1:0]  out_count
);

    // Handshake: a beat/result transfers on a rising edge where valid and ready
    // are both 1; in_ready and out_valid are registered and never both 1.

    sacc_state_e       state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic              ov_q, ov_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] add_sum;
    logic              add_cout;
    logic              add_ov;
    logic [DATA_W-1:0] acc_next;
    logic [CNT_W-1:0]  count_inc;
    logic              accept;
    logic              close;

    four_bit_signed_adder_with_ov u_adder (
        .a    (acc_q),
        .b    (in_data),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout),
        .ov   (add_ov)
    );

`ifdef SACC_SATURATE_EN
    // Clamp toward the sign of the running sum; operands alone can't flip it.
    assign acc_next = add_ov ? (acc_q[DATA_W-1] ? SAT_NEG : SAT_POS) : add_sum;
`else
    assign acc_next = add_sum;
`endif

    assign count_inc = count_q + CNT_W'(1);
    assign accept    = in_valid & in_ready_q & ~clear;
    assign close     = in_last | (count_inc == CNT_W'(MAX_BEATS));

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ov_d    = ov_q;
        count_d = count_q;
        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            ov_d    = 1'b0;
            count_d = '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_d   = acc_next;
                        ov_d    = ov_q | add_ov;
                        count_d = count_inc;
                        state_d = close ? DONE : ACCUM;
                    end
                end
                DONE: begin
                    if (out_valid_q && out_ready) begin
                        state_d = IDLE;
                        acc_d   = '0;
                        ov_d    = 1'b0;
                        count_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        in_ready_d  = (state_d != DONE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            ov_q        <= 1'b0;
            count_q     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            ov_q        <= ov_d;
            count_q     <= count_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_ov    = ov_q;
    assign out_count = count_q;

endmodule

// File: tb/tb_signed_frame_accumulator.sv
// Directed self-checking bench for signed_frame_accumulator (MAX_BEATS=4).
module tb_signed_frame_accumulator;

    localparam int MAX_BEATS = 4;
    localparam int CNT_W     = $clog2(MAX_BEATS + 1);

    logic             clk;
    logic             rst_n;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_data;
    logic             out_ov;
    logic [CNT_W-1:0] out_count;

    int vectors;
    int miscompares;

    signed_frame_accumulator #(.MAX_BEATS(MAX_BEATS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ov    (out_ov),
        .out_count (out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [3:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        if (n >= 20) chk("beat_timeout", 8'(n), 8'd0);
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 4'h0;
    endtask

    task automatic expect_result(input string tag, input logic [3:0] d,
                                 input logic ov, input logic [CNT_W-1:0] cnt);
        chk({tag, "_valid"}, 8'(out_valid), 8'd1);
        chk({tag, "_data"}, 8'(out_data), 8'(d));
        chk({tag, "_ov"}, 8'(out_ov), 8'(ov));
        chk({tag, "_count"}, 8'(out_count), 8'(cnt));
        chk({tag, "_in_ready"}, 8'(in_ready), 8'd0);
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({tag, "_hs_valid"}, 8'(out_valid), 8'd0);
        chk({tag, "_hs_in_ready"}, 8'(in_ready), 8'd1);
        chk({tag, "_hs_count"}, 8'(out_count), 8'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        clear       = 1'b0;
        in_valid    = 1'b0;
        in_data     = 4'h0;
        in_last     = 1'b0;
        out_ready   = 1'b0;

        // Reset state
        #2;
        chk("rst_in_ready", 8'(in_ready), 8'd0);
        chk("rst_out_valid", 8'(out_valid), 8'd0);
        chk("rst_out_data", 8'(out_data), 8'd0);
        chk("rst_out_ov", 8'(out_ov), 8'd0);
        chk("rst_out_count", 8'(out_count), 8'd0);
        step();
        step();
        rst_n = 1'b1;
        chk("post_rel_in_ready_low", 8'(in_ready), 8'd0);
        step();
        chk("post_rel_in_ready", 8'(in_ready), 8'd1);

        // 3 + 2 + 1 = 6, result the cycle after the last beat
        send_beat(4'h3, 1'b0);
        chk("f1_mid_valid", 8'(out_valid), 8'd0);
        send_beat(4'h2, 1'b0);
        send_beat(4'h1, 1'b1);
        expect_result("f1", 4'h6, 1'b0, 3'd3);
        handshake("f1");

        // 7 + 1 overflows
        send_beat(4'h7, 1'b0);
        send_beat(4'h1, 1'b1);
`ifdef SACC_SATURATE_EN
        expect_result("f2", 4'h7, 1'b1, 3'd2);
`else
        expect_result("f2", 4'h8, 1'b1, 3'd2);
`endif
        handshake("f2");

        // -8 - 1 + 2: overflow stays sticky after returning in range
        send_beat(4'h8, 1'b0);
        send_beat(4'hF, 1'b0);
`ifdef SACC_SATURATE_EN
        chk("f3_mid_acc", 8'(out_data), 8'h8);
`else
        chk("f3_mid_acc", 8'(out_data), 8'h7);
`endif
        chk("f3_mid_ov", 8'(out_ov), 8'd1);
        send_beat(4'h2, 1'b1);
`ifdef SACC_SATURATE_EN
        expect_result("f3", 4'hA, 1'b1, 3'd3);
`else
        expect_result("f3", 4'h9, 1'b1, 3'd3);
`endif
        handshake("f3");

        // Auto-close at MAX_BEATS, fifth beat stalls until the handshake
        for (int i = 0; i < 4; i++) send_beat(4'h1, 1'b0);
        expect_result("f4", 4'h4, 1'b0, 3'd4);
        in_valid = 1'b1;
        in_data  = 4'h1;
        in_last  = 1'b0;
        step();
        chk("f4_stall_in_ready", 8'(in_ready), 8'd0);
        chk("f4_stall_data", 8'(out_data), 8'h4);
        chk("f4_stall_count", 8'(out_count), 8'd4);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("f4_hs_valid", 8'(out_valid), 8'd0);
        chk("f4_hs_in_ready", 8'(in_ready), 8'd1);
        chk("f4_hs_count", 8'(out_count), 8'd0);
        step();
        in_valid = 1'b0;
        chk("f5_first_count", 8'(out_count), 8'd1);
        chk("f5_first_valid", 8'(out_valid), 8'd0);
        send_beat(4'h0, 1'b1);
        expect_result("f5", 4'h1, 1'b0, 3'd2);
        handshake("f5");

        // Back-pressure: hold result for 5 cycles
        send_beat(4'hD, 1'b0);
        send_beat(4'h2, 1'b1);
        for (int i = 0; i < 5; i++) begin
            expect_result("hold", 4'hF, 1'b0, 3'd2);
            step();
        end
        handshake("hold");

        // in_last without in_valid is ignored; clear aborts the frame
        send_beat(4'h2, 1'b0);
        send_beat(4'h3, 1'b0);
        in_last = 1'b1;
        step();
        in_last = 1'b0;
        chk("lastnv_valid", 8'(out_valid), 8'd0);
        chk("lastnv_count", 8'(out_count), 8'd2);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h5;
        step();
        clear    = 1'b0;
        in_valid = 1'b0;
        chk("clr_valid", 8'(out_valid), 8'd0);
        chk("clr_in_ready", 8'(in_ready), 8'd1);
        chk("clr_data", 8'(out_data), 8'd0);
        chk("clr_count", 8'(out_count), 8'd0);
        chk("clr_ov", 8'(out_ov), 8'd0);
        send_beat(4'h1, 1'b1);
        expect_result("after_clr", 4'h1, 1'b0, 3'd1);
        handshake("after_clr");

        // Asynchronous reset mid-frame
        send_beat(4'h2, 1'b0);
        send_beat(4'h3, 1'b0);
        chk("pre_rst_data", 8'(out_data), 8'h5);
        chk("pre_rst_count", 8'(out_count), 8'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", 8'(out_data), 8'd0);
        chk("arst_count", 8'(out_count), 8'd0);
        chk("arst_ov", 8'(out_ov), 8'd0);
        chk("arst_valid", 8'(out_valid), 8'd0);
        chk("arst_in_ready", 8'(in_ready), 8'd0);
        step();
        rst_n = 1'b1;
        step();
        chk("arst_rel_in_ready", 8'(in_ready), 8'd1);
        send_beat(4'h4, 1'b1);
        expect_result("after_rst", 4'h4, 1'b0, 3'd1);
        handshake("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
